// File: rtl/aes_enc_arbiter.sv
// ---------------------------------------------------------------------------
// aes_enc_arbiter
//
// Shares a single AES encryption core among NUM_REQ requesters. Requesters
// are granted round-robin. The granted key/plaintext is latched onto the
// core pins and the core is strobed for one cycle. The arbiter then waits for
// the core's done pulse, or gives up after TIMEOUT cycles. Finally it returns
// the ciphertext, tagged with the requester ID, over a valid/ready response
// channel.
//
// Ports
//   clk            clock, all state updates on the rising edge
//   rst            synchronous, active-low reset
//   req_valid      per-requester request valid
//   req_ready      per-requester accept, one-hot or zero, only in IDLE
//   req_key        flattened 256-bit keys, requester i at [i*256 +: 256]
//   req_text       flattened 128-bit plaintexts, requester i at [i*128 +: 128]
//   core_ld        one-cycle load strobe to the core
//   core_key       key presented to the core (stable from LOAD to next grant)
//   core_text_in   plaintext presented to the core (same stability)
//   core_done      core completion pulse, honoured only while BUSY
//   core_text_out  core ciphertext, valid in the core_done cycle
//   resp_valid     response valid (state RESP)
//   resp_ready     response accept
//   resp_data      ciphertext, zero on timeout
//   resp_id        requester that owns the response
//   resp_err       1 = transaction aborted by timeout
//   busy           1 whenever the arbiter is not IDLE
// ---------------------------------------------------------------------------
module aes_enc_arbiter #(
    parameter int NUM_REQ = 4,
    parameter int ID_W    = 2,
    parameter int TIMEOUT = 32,
    parameter int CNT_W   = 6
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [NUM_REQ-1:0]     req_valid,
    output logic [NUM_REQ-1:0]     req_ready,
    input  logic [NUM_REQ*256-1:0] req_key,
    input  logic [NUM_REQ*128-1:0] req_text,
    output logic                   core_ld,
    output logic [255:0]           core_key,
    output logic [127:0]           core_text_in,
    input  logic                   core_done,
    input  logic [127:0]           core_text_out,
    output logic                   resp_valid,
    input  logic                   resp_ready,
    output logic [127:0]           resp_data,
    output logic [ID_W-1:0]        resp_id,
    output logic                   resp_err,
    output logic                   busy
);

    // -----------------------------------------------------------------------
    // FSM encoding
    // -----------------------------------------------------------------------
    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_LOAD = 2'd1;
    localparam logic [1:0] S_BUSY = 2'd2;
    localparam logic [1:0] S_RESP = 2'd3;

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);
    localparam logic [ID_W-1:0]  ID_LAST  = ID_W'(NUM_REQ - 1);

    // -----------------------------------------------------------------------
    // State
    // -----------------------------------------------------------------------
    logic [1:0]       state_q,      state_d;
    logic [ID_W-1:0]  last_grant_q, last_grant_d;
    logic [CNT_W-1:0] cnt_q,        cnt_d;
    logic [255:0]     key_q,        key_d;
    logic [127:0]     text_q,       text_d;
    logic [127:0]     rdata_q,      rdata_d;
    logic [ID_W-1:0]  rid_q,        rid_d;
    logic             rerr_q,       rerr_d;

    // Round-robin arbitration result
    logic             grant_valid;
    logic [ID_W-1:0]  grant_idx;

    // (base + off) mod NUM_REQ. base < NUM_REQ and off <= NUM_REQ, so a
    // single conditional subtraction is enough.
    function automatic logic [ID_W-1:0] rr_index(input logic [ID_W-1:0] base,
                                                 input int off);
        int sum;
        sum = int'(base) + off;
        if (sum >= NUM_REQ) sum = sum - NUM_REQ;
        return ID_W'(sum);
    endfunction

    // -----------------------------------------------------------------------
    // Round-robin search: the first valid requester after last_grant, with
    // wrap-around. last_grant itself is visited last (off == NUM_REQ), so a
    // lone requester can be granted again.
    // -----------------------------------------------------------------------
    always_comb begin
        // NOTE: every signal written in a combinational block gets a default
        // first; a path that leaves one unassigned would infer a latch.
        grant_valid = 1'b0;
        grant_idx   = '0;
        for (int off = 1; off <= NUM_REQ; off++) begin
            if (!grant_valid && req_valid[rr_index(last_grant_q, off)]) begin
                grant_valid = 1'b1;
                grant_idx   = rr_index(last_grant_q, off);
            end
        end
    end

    // The accept is combinational and is offered only in IDLE. It is also
    // held low while reset is asserted, because the reset edge discards any
    // grant.
    always_comb begin
        req_ready = '0;
        if (rst && (state_q == S_IDLE) && grant_valid) begin
            req_ready[grant_idx] = 1'b1;
        end
    end

    // -----------------------------------------------------------------------
    // Next-state logic
    // -----------------------------------------------------------------------
    always_comb begin
        state_d      = state_q;
        last_grant_d = last_grant_q;
        cnt_d        = cnt_q;
        key_d        = key_q;
        text_d       = text_q;
        rdata_d      = rdata_q;
        rid_d        = rid_q;
        rerr_d       = rerr_q;

        case (state_q)
            S_IDLE: begin
                if (grant_valid) begin
                    key_d        = req_key[int'(grant_idx) * 256 +: 256];
                    text_d       = req_text[int'(grant_idx) * 128 +: 128];
                    rid_d        = grant_idx;
                    last_grant_d = grant_idx;
                    state_d      = S_LOAD;
                end
            end

            S_LOAD: begin
                cnt_d   = '0;
                state_d = S_BUSY;
            end

            S_BUSY: begin
                // A done pulse takes priority over a timeout in the same cycle.
                if (core_done) begin
                    rdata_d = core_text_out;
                    rerr_d  = 1'b0;
                    state_d = S_RESP;
                end else if (cnt_q == CNT_LAST) begin
                    rdata_d = '0;
                    rerr_d  = 1'b1;
                    state_d = S_RESP;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end

            S_RESP: begin
                if (resp_ready) begin
                    state_d = S_IDLE;
                end
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // -----------------------------------------------------------------------
    // Registers
    // -----------------------------------------------------------------------
    always_ff @(posedge clk) begin
        // NOTE: the wide data registers are reset as well, because they drive
        // output pins that must read zero after reset. Plain storage with no
        // such visibility could skip the reset.
        if (!rst) begin
            // NOTE: sequential state is written with non-blocking assignments,
            // so every register samples its pre-edge inputs.
            state_q      <= S_IDLE;
            last_grant_q <= ID_LAST;
            cnt_q        <= '0;
            key_q        <= '0;
            text_q       <= '0;
            rdata_q      <= '0;
            rid_q        <= '0;
            rerr_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            last_grant_q <= last_grant_d;
            cnt_q        <= cnt_d;
            key_q        <= key_d;
            text_q       <= text_d;
            rdata_q      <= rdata_d;
            rid_q        <= rid_d;
            rerr_q       <= rerr_d;
        end
    end

    // -----------------------------------------------------------------------
    // Outputs
    // -----------------------------------------------------------------------
    assign core_ld      = (state_q == S_LOAD);
    assign core_key     = key_q;
    assign core_text_in = text_q;
    assign resp_valid   = (state_q == S_RESP);
    assign resp_data    = rdata_q;
    assign resp_id      = rid_q;
    assign resp_err     = rerr_q;
    assign busy         = (state_q != S_IDLE);

endmodule

// File: tb/tb_aes_enc_arbiter.sv
// ---------------------------------------------------------------------------
// tb_aes_enc_arbiter
//
// Directed bench for aes_enc_arbiter. A behavioural core returns
// text_in ^ key[127:0], core_lat cycles after the load strobe (core_lat = 0:
// never). A negedge monitor records grants, load strobes, BUSY cycles and
// illegal accepts. Each scenario task drives its stimulus and compares the
// outputs against hand-derived values.
// ---------------------------------------------------------------------------
module tb_aes_enc_arbiter;

    localparam int NUM_REQ = 4;
    localparam int ID_W    = 2;
    localparam int TIMEOUT = 32;
    localparam int CNT_W   = 6;

    logic                   clk;
    logic                   rst;
    logic [NUM_REQ-1:0]     req_valid;
    logic [NUM_REQ-1:0]     req_ready;
    logic [NUM_REQ*256-1:0] req_key;
    logic [NUM_REQ*128-1:0] req_text;
    logic                   core_ld;
    logic [255:0]           core_key;
    logic [127:0]           core_text_in;
    logic                   core_done;
    logic [127:0]           core_text_out;
    logic                   resp_valid;
    logic                   resp_ready;
    logic [127:0]           resp_data;
    logic [ID_W-1:0]        resp_id;
    logic                   resp_err;
    logic                   busy;

    int n_cmp;
    int n_bad;

    // core model configuration/state
    int core_lat;
    int cd;
    bit cd_active;

    // monitor records
    int grant_cnt;
    int ld_cnt;
    int busy_cnt;
    int bad_ready;
    int grant_ids[$];

    logic [255:0] keys  [NUM_REQ];
    logic [127:0] texts [NUM_REQ];

    aes_enc_arbiter #(
        .NUM_REQ (NUM_REQ),
        .ID_W    (ID_W),
        .TIMEOUT (TIMEOUT),
        .CNT_W   (CNT_W)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .req_valid     (req_valid),
        .req_ready     (req_ready),
        .req_key       (req_key),
        .req_text      (req_text),
        .core_ld       (core_ld),
        .core_key      (core_key),
        .core_text_in  (core_text_in),
        .core_done     (core_done),
        .core_text_out (core_text_out),
        .resp_valid    (resp_valid),
        .resp_ready    (resp_ready),
        .resp_data     (resp_data),
        .resp_id       (resp_id),
        .resp_err      (resp_err),
        .busy          (busy)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Behavioural core. If ld is seen in cycle L, done is high during cycle
    // L + core_lat. A pending done survives an arbiter reset, which makes it
    // arrive as a stray pulse.
    initial begin
        core_done     = 1'b0;
        core_text_out = '0;
        cd            = 0;
        cd_active     = 1'b0;
        forever begin
            @(negedge clk);
            core_done = 1'b0;
            if (cd_active) begin
                cd = cd - 1;
                if (cd == 0) begin
                    core_done = 1'b1;
                    cd_active = 1'b0;
                end
            end
            if (core_ld === 1'b1) begin
                core_text_out = core_text_in ^ core_key[127:0];
                if (core_lat != 0) begin
                    cd        = core_lat;
                    cd_active = 1'b1;
                end
            end
        end
    end

    // Monitor, sampling 1 ns after each falling edge.
    initial begin
        grant_cnt = 0;
        ld_cnt    = 0;
        busy_cnt  = 0;
        bad_ready = 0;
        forever begin
            @(negedge clk);
            #1;
            if (req_ready !== '0 && !$isunknown(req_ready)) begin
                grant_cnt++;
                for (int i = 0; i < NUM_REQ; i++) begin
                    if (req_ready[i]) grant_ids.push_back(i);
                end
            end
            if (core_ld === 1'b1) ld_cnt++;
            if (busy === 1'b1 && core_ld === 1'b0 && resp_valid === 1'b0) busy_cnt++;
            if ((busy === 1'b1 && req_ready !== '0) || $countones(req_ready) > 1) bad_ready++;
        end
    end

    // ---------------------------------------------------------------------
    // Stimulus helpers (no comparisons inside)
    // ---------------------------------------------------------------------
    task automatic clear_mon();
        grant_cnt = 0;
        ld_cnt    = 0;
        busy_cnt  = 0;
        grant_ids.delete();
    endtask

    task automatic set_req(input int i, input logic [255:0] k, input logic [127:0] t);
        keys[i]  = k;
        texts[i] = t;
        req_key[i*256 +: 256] = k;
        req_text[i*128 +: 128] = t;
    endtask

    task automatic wait_resp(input int budget, output bit got);
        got = 1'b0;
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            if (resp_valid === 1'b1) begin
                got = 1'b1;
                break;
            end
        end
    endtask

    task automatic accept_resp();
        resp_ready = 1'b1;
        @(negedge clk);
        resp_ready = 1'b0;
    endtask

    task automatic do_reset();
        rst = 1'b0;
        @(negedge clk);
        rst = 1'b1;
    endtask

    function automatic int first_grant();
        return (grant_ids.size() > 0) ? grant_ids[0] : -1;
    endfunction

    // ---------------------------------------------------------------------
    // Scenarios
    // ---------------------------------------------------------------------
    task automatic test_reset();
        rst        = 1'b0;
        req_valid  = '0;
        resp_ready = 1'b0;
        req_key    = '0;
        req_text   = '0;
        core_lat   = 0;
        repeat (2) @(negedge clk);
        n_cmp++; if (req_ready !== 4'h0) begin n_bad++; $display("FAIL reset_req_ready: got %h expected 0", req_ready); end
        n_cmp++; if (core_ld !== 1'b0) begin n_bad++; $display("FAIL reset_core_ld: got %b expected 0", core_ld); end
        n_cmp++; if (core_key !== 256'h0) begin n_bad++; $display("FAIL reset_core_key: got %h expected 0", core_key); end
        n_cmp++; if (core_text_in !== 128'h0) begin n_bad++; $display("FAIL reset_core_text_in: got %h expected 0", core_text_in); end
        n_cmp++; if (resp_valid !== 1'b0) begin n_bad++; $display("FAIL reset_resp_valid: got %b expected 0", resp_valid); end
        n_cmp++; if (resp_data !== 128'h0) begin n_bad++; $display("FAIL reset_resp_data: got %h expected 0", resp_data); end
        n_cmp++; if (resp_id !== 2'd0) begin n_bad++; $display("FAIL reset_resp_id: got %h expected 0", resp_id); end
        n_cmp++; if (resp_err !== 1'b0) begin n_bad++; $display("FAIL reset_resp_err: got %b expected 0", resp_err); end
        n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL reset_busy: got %b expected 0", busy); end
        rst = 1'b1;
        @(negedge clk);
        n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL reset_idle_after: got busy=%b expected 0", busy); end
    endtask

    task automatic test_single();
        bit got;
        clear_mon();
        set_req(2, 256'h1, 128'h00112233445566778899aabbccddeeff);
        core_lat  = 14;
        req_valid = 4'b0100;
        wait_resp(80, got);
        req_valid = '0;
        n_cmp++; if (!got) begin n_bad++; $display("FAIL single_resp_seen: got none expected resp_valid"); end
        n_cmp++; if (grant_cnt !== 1) begin n_bad++; $display("FAIL single_grant_count: got %0d expected 1", grant_cnt); end
        n_cmp++; if (first_grant() !== 2) begin n_bad++; $display("FAIL single_grant_id: got %0d expected 2", first_grant()); end
        n_cmp++; if (ld_cnt !== 1) begin n_bad++; $display("FAIL single_ld_cycles: got %0d expected 1", ld_cnt); end
        n_cmp++; if (busy_cnt !== 14) begin n_bad++; $display("FAIL single_busy_cycles: got %0d expected 14", busy_cnt); end
        n_cmp++; if (resp_id !== 2'd2) begin n_bad++; $display("FAIL single_resp_id: got %0d expected 2", resp_id); end
        n_cmp++; if (resp_data !== 128'h00112233445566778899aabbccddeefe) begin n_bad++; $display("FAIL single_resp_data: got %h expected 00112233445566778899aabbccddeefe", resp_data); end
        n_cmp++; if (resp_err !== 1'b0) begin n_bad++; $display("FAIL single_resp_err: got %b expected 0", resp_err); end
        n_cmp++; if (core_key !== 256'h1) begin n_bad++; $display("FAIL single_core_key_hold: got %h expected 1", core_key); end
        n_cmp++; if (core_text_in !== 128'h00112233445566778899aabbccddeeff) begin n_bad++; $display("FAIL single_core_text_hold: got %h", core_text_in); end
        accept_resp();
        n_cmp++; if (resp_valid !== 1'b0 || busy !== 1'b0) begin n_bad++; $display("FAIL single_back_to_idle: got valid=%b busy=%b expected 0/0", resp_valid, busy); end
    endtask

    task automatic test_round_robin();
        bit got;
        int repeats;
        do_reset();
        for (int i = 0; i < NUM_REQ; i++) begin
            set_req(i, {128'hdeadbeef_00000000_00000000_00000000, 128'h11111111_11111111_11111111_11111111 * (i + 1)},
                    128'h01020304_05060708_090a0b0c_0d0e0f10 << (4 * i));
        end
        clear_mon();
        core_lat  = 3;
        req_valid = 4'hf;
        for (int t = 0; t < 8; t++) begin
            wait_resp(40, got);
            n_cmp++;
            if (!got) begin
                n_bad++;
                $display("FAIL rr_resp_seen_%0d: got none expected resp_valid", t);
                break;
            end
            n_cmp++; if (resp_id !== 2'(t % 4)) begin n_bad++; $display("FAIL rr_resp_id_%0d: got %0d expected %0d", t, resp_id, t % 4); end
            n_cmp++; if (resp_data !== (texts[t % 4] ^ keys[t % 4][127:0])) begin n_bad++; $display("FAIL rr_resp_data_%0d: got %h expected %h", t, resp_data, texts[t % 4] ^ keys[t % 4][127:0]); end
            accept_resp();
        end
        req_valid = '0;
        n_cmp++; if (grant_cnt !== 8) begin n_bad++; $display("FAIL rr_grant_count: got %0d expected 8", grant_cnt); end
        repeats = 0;
        for (int t = 0; t < grant_ids.size(); t++) begin
            n_cmp++; if (grant_ids[t] !== t % 4) begin n_bad++; $display("FAIL rr_order_%0d: got %0d expected %0d", t, grant_ids[t], t % 4); end
            if (t > 0 && grant_ids[t] == grant_ids[t-1]) repeats++;
        end
        n_cmp++; if (repeats !== 0) begin n_bad++; $display("FAIL rr_no_repeat: got %0d repeats expected 0", repeats); end
    endtask

    task automatic test_backpressure();
        bit got;
        logic [127:0] exp_data;
        exp_data = texts[1] ^ keys[1][127:0];
        clear_mon();
        core_lat  = 5;
        req_valid = 4'b0010;
        wait_resp(40, got);
        n_cmp++; if (!got) begin n_bad++; $display("FAIL bp_resp_seen: got none expected resp_valid"); end
        req_valid = 4'b1101;
        clear_mon();
        for (int i = 0; i < 10; i++) begin
            n_cmp++;
            if ({resp_valid, resp_id, resp_data, resp_err} !== {1'b1, 2'd1, exp_data, 1'b0}) begin
                n_bad++;
                $display("FAIL bp_hold_%0d: got v=%b id=%0d d=%h e=%b expected v=1 id=1 d=%h e=0",
                         i, resp_valid, resp_id, resp_data, resp_err, exp_data);
            end
            @(negedge clk);
        end
        n_cmp++; if (grant_cnt !== 0) begin n_bad++; $display("FAIL bp_no_ready: got %0d accepts expected 0", grant_cnt); end
        resp_ready = 1'b1;
        @(negedge clk);
        resp_ready = 1'b0;
        n_cmp++; if (resp_valid !== 1'b0 || busy !== 1'b0) begin n_bad++; $display("FAIL bp_idle_next: got valid=%b busy=%b expected 0/0", resp_valid, busy); end
        n_cmp++; if (req_ready !== 4'b0100) begin n_bad++; $display("FAIL bp_next_grant: got %b expected 0100", req_ready); end
        req_valid = '0;
    endtask

    task automatic test_timeout();
        bit got;
        clear_mon();
        core_lat  = 0;
        req_valid = 4'b0001;
        wait_resp(100, got);
        req_valid = '0;
        n_cmp++; if (!got) begin n_bad++; $display("FAIL to_resp_seen: got none expected resp_valid"); end
        n_cmp++; if (busy_cnt !== TIMEOUT) begin n_bad++; $display("FAIL to_busy_cycles: got %0d expected %0d", busy_cnt, TIMEOUT); end
        n_cmp++; if (resp_err !== 1'b1) begin n_bad++; $display("FAIL to_resp_err: got %b expected 1", resp_err); end
        n_cmp++; if (resp_data !== 128'h0) begin n_bad++; $display("FAIL to_resp_data: got %h expected 0", resp_data); end
        n_cmp++; if (resp_id !== 2'd0) begin n_bad++; $display("FAIL to_resp_id: got %0d expected 0", resp_id); end
        accept_resp();
        clear_mon();
        core_lat  = 10;
        req_valid = 4'b1000;
        wait_resp(60, got);
        req_valid = '0;
        n_cmp++; if (!got) begin n_bad++; $display("FAIL to_next_seen: got none expected resp_valid"); end
        n_cmp++; if (busy_cnt !== 10) begin n_bad++; $display("FAIL to_next_busy: got %0d expected 10", busy_cnt); end
        n_cmp++; if (resp_err !== 1'b0 || resp_id !== 2'd3) begin n_bad++; $display("FAIL to_next_status: got err=%b id=%0d expected 0/3", resp_err, resp_id); end
        n_cmp++; if (resp_data !== (texts[3] ^ keys[3][127:0])) begin n_bad++; $display("FAIL to_next_data: got %h expected %h", resp_data, texts[3] ^ keys[3][127:0]); end
        accept_resp();
    endtask

    task automatic test_done_on_timeout();
        bit got;
        clear_mon();
        core_lat  = TIMEOUT;
        req_valid = 4'b0001;
        wait_resp(100, got);
        req_valid = '0;
        n_cmp++; if (!got) begin n_bad++; $display("FAIL dt_resp_seen: got none expected resp_valid"); end
        n_cmp++; if (busy_cnt !== TIMEOUT) begin n_bad++; $display("FAIL dt_busy_cycles: got %0d expected %0d", busy_cnt, TIMEOUT); end
        n_cmp++; if (resp_err !== 1'b0) begin n_bad++; $display("FAIL dt_resp_err: got %b expected 0", resp_err); end
        n_cmp++; if (resp_data !== (texts[0] ^ keys[0][127:0])) begin n_bad++; $display("FAIL dt_resp_data: got %h expected %h", resp_data, texts[0] ^ keys[0][127:0]); end
        accept_resp();
    endtask

    task automatic test_mid_reset();
        bit got;
        int stray;
        clear_mon();
        core_lat  = 20;
        req_valid = 4'b0100;
        for (int i = 0; i < 40 && busy_cnt < 5; i++) @(negedge clk);
        req_valid = '0;
        n_cmp++; if (busy_cnt < 5) begin n_bad++; $display("FAIL mr_reach_busy: got %0d busy cycles expected 5", busy_cnt); end
        rst = 1'b0;
        @(negedge clk);
        n_cmp++; if ({req_ready, core_ld, resp_valid, resp_err, busy, resp_id} !== '0) begin n_bad++; $display("FAIL mr_ctrl_zero: got rdy=%b ld=%b v=%b e=%b busy=%b id=%0d expected all 0", req_ready, core_ld, resp_valid, resp_err, busy, resp_id); end
        n_cmp++; if ({core_key, core_text_in, resp_data} !== '0) begin n_bad++; $display("FAIL mr_data_zero: got key=%h txt=%h d=%h expected 0", core_key, core_text_in, resp_data); end
        rst = 1'b1;
        stray = 0;
        for (int i = 0; i < 25; i++) begin
            @(negedge clk);
            if (resp_valid !== 1'b0 || busy !== 1'b0) stray++;
        end
        n_cmp++; if (stray !== 0) begin n_bad++; $display("FAIL mr_stray_done: got %0d active cycles expected 0", stray); end
        n_cmp++; if (resp_data !== 128'h0 || resp_err !== 1'b0) begin n_bad++; $display("FAIL mr_outputs_after_stray: got d=%h e=%b expected 0/0", resp_data, resp_err); end
        clear_mon();
        core_lat  = 4;
        req_valid = 4'hf;
        wait_resp(40, got);
        req_valid = '0;
        n_cmp++; if (!got) begin n_bad++; $display("FAIL mr_next_seen: got none expected resp_valid"); end
        n_cmp++; if (first_grant() !== 0 || resp_id !== 2'd0) begin n_bad++; $display("FAIL mr_next_grant: got grant=%0d id=%0d expected 0/0", first_grant(), resp_id); end
        n_cmp++; if (resp_data !== (texts[0] ^ keys[0][127:0])) begin n_bad++; $display("FAIL mr_next_data: got %h expected %h", resp_data, texts[0] ^ keys[0][127:0]); end
        accept_resp();
    endtask

    task automatic test_ready_rules();
        n_cmp++; if (bad_ready !== 0) begin n_bad++; $display("FAIL ready_rules: got %0d illegal accept cycles expected 0", bad_ready); end
    endtask

    initial begin
        n_cmp = 0;
        n_bad = 0;
        test_reset();
        test_single();
        test_round_robin();
        test_backpressure();
        test_timeout();
        test_done_on_timeout();
        test_mid_reset();
        test_ready_rules();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
